timer_sched: RTL and testbench

TIMER_SCHED -- requirements
Module: timer_sched

---
 rtl/timer_sched_pkg.sv | 18 +
 rtl/timer_sched_rr_arbiter.sv | 45 ++++
 rtl/timer_sched.sv | 175 +++++++++++++++++
 tb/tb_timer_sched.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_sched_pkg.sv
// timer_sched_pkg: shared types and constants for the timer scheduler.
// State encoding is exported so the top can expose it on dbg_state.
package timer_sched_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_CW      = 32;
  // Cycles of slack past the programmed delay before the watchdog fires.
  localparam int WD_MARGIN   = 2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_WAIT = 3'd2,
    S_CAPT = 3'd3,
    S_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/timer_sched_rr_arbiter.sv
// rr_arbiter: round-robin arbiter with a one-hot grant.
// The search starts one past the last accepted index and wraps to 0.
// The pointer only moves when the grant is actually accepted (i_accept),
// so a requester that withdraws before handshake does not consume a turn.
module rr_arbiter
  import timer_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_an,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_accept,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IW-1:0]      o_grant_idx
);

  logic [IW-1:0] r_last;
  logic [IW-1:0] w_cand;
  logic          w_found;

  // Pick the first active requester after r_last, wrapping around.
  always_comb begin
    w_found     = 1'b0;
    w_cand      = '0;
    o_grant_idx = '0;
    o_grant     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = IW'((int'(r_last) + k) % NUM_REQ);
      if (!w_found && i_req[w_cand]) begin
        w_found     = 1'b1;
        o_grant_idx = w_cand;
      end
    end
    if (w_found) o_grant[o_grant_idx] = 1'b1;
  end

  // Remember the last accepted index; reset makes requester 0 win first.
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an)       r_last <= IW'(NUM_REQ - 1);
    else if (i_accept) r_last <= o_grant_idx;
  end

endmodule

// File: rtl/timer_sched.sv
// timer_sched: shares one external timer among NUM_REQ alarm requesters.
// Optional feature macro: TIMER_SCHED_CANCEL_EN enables owner cancel via a
// capture of the live count (CAPT state). Without it cancel is ignored.
// Handshake: a request transfers on a rising clk edge where
// req_valid[i] & req_ready[i]; req_ready is one-hot and only high in IDLE.
module timer_sched
  import timer_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int CW      = DEF_CW
) (
  input  logic                  clk,
  input  logic                  rst_an,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*CW-1:0] req_delay,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ-1:0]    cancel,
  output logic [NUM_REQ-1:0]    done,
  output logic                  done_err,
  output logic                  done_cancel,
  output logic [CW-1:0]         done_elapsed,
  output logic                  busy,
  output logic                  tmr_start,
  output logic [CW-1:0]         tmr_alarm,
  output logic                  tmr_alarm_en,
  output logic                  tmr_capture,
  input  logic [CW-1:0]         tmr_counter,
  input  logic [CW-1:0]         tmr_captured,
  input  logic                  tmr_alarm_out,
  output logic [2:0]            dbg_state
);

  localparam int IW = $clog2(NUM_REQ);

  state_t              r_state;
  state_t              w_next;
  logic [IW-1:0]       r_grant_idx;
  logic [CW-1:0]       r_delay;
  logic [CW-1:0]       r_elapsed;
  logic                r_err;
  logic                r_cancel;
  logic                r_alarm_q;
  logic [NUM_REQ-1:0]  w_grant;
  logic [IW-1:0]       w_grant_idx;
  logic [CW-1:0]       w_req_delay;
  logic                w_hs;
  logic                w_alarm_edge;
  logic                w_wd;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
    .clk         (clk),
    .rst_an      (rst_an),
    .i_req       (req_valid),
    .i_accept    (w_hs),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx)
  );

  assign w_hs         = (r_state == S_IDLE) && (|(w_grant & req_valid));
  assign w_req_delay  = req_delay[w_grant_idx*CW +: CW];
  assign w_alarm_edge = tmr_alarm_out & ~r_alarm_q;
  // Widened by one bit so delay = all-ones cannot wrap below the counter.
  assign w_wd         = ({1'b0, tmr_counter} > ({1'b0, r_delay} + (CW+1)'(WD_MARGIN)));
  assign dbg_state    = r_state;

`ifdef TIMER_SCHED_CANCEL_EN
  logic r_capt_phase;
  logic w_cancel;
  // Only the owner of the active alarm can cancel it.
  assign w_cancel = cancel[r_grant_idx];
`else
  logic w_unused_cancel;
  assign w_unused_cancel = ^{cancel, tmr_captured};
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic; an alarm edge has priority over cancel and watchdog.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_hs) w_next = (w_req_delay == '0) ? S_DONE : S_ARM;
      S_ARM:  w_next = S_WAIT;
      S_WAIT: begin
        if (w_alarm_edge)  w_next = S_DONE;
`ifdef TIMER_SCHED_CANCEL_EN
        else if (w_cancel) w_next = S_CAPT;
`endif
        else if (w_wd)     w_next = S_DONE;
      end
`ifdef TIMER_SCHED_CANCEL_EN
      S_CAPT: if (r_capt_phase) w_next = S_DONE;
`endif
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the state; all fall at once on reset.
  always_comb begin
    busy         = (r_state != S_IDLE);
    req_ready    = (r_state == S_IDLE) ? w_grant : '0;
    tmr_start    = (r_state == S_WAIT) || (r_state == S_CAPT);
    tmr_alarm_en = (r_state == S_ARM)  || (r_state == S_WAIT);
    tmr_alarm    = r_delay;
    tmr_capture  = 1'b0;
`ifdef TIMER_SCHED_CANCEL_EN
    tmr_capture  = (r_state == S_CAPT) && !r_capt_phase;
`endif
    done         = '0;
    if (r_state == S_DONE) done[r_grant_idx] = 1'b1;
    done_err     = (r_state == S_DONE) && r_err;
    done_cancel  = (r_state == S_DONE) && r_cancel;
    done_elapsed = r_elapsed;
  end

  // Alarm edge detector history.
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) r_alarm_q <= 1'b0;
    else         r_alarm_q <= tmr_alarm_out;
  end

  // Request context and completion status captured along the way.
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      r_grant_idx <= '0;
      r_delay     <= '0;
      r_elapsed   <= '0;
      r_err       <= 1'b0;
      r_cancel    <= 1'b0;
    end else begin
      if (w_hs) begin
        r_grant_idx <= w_grant_idx;
        r_delay     <= w_req_delay;
        r_elapsed   <= '0;
        r_err       <= 1'b0;
        r_cancel    <= 1'b0;
      end else if (r_state == S_WAIT) begin
        if (w_alarm_edge) begin
          r_elapsed <= tmr_counter;
        end else if (w_wd) begin
`ifdef TIMER_SCHED_CANCEL_EN
          if (!w_cancel) begin
            r_elapsed <= tmr_counter;
            r_err     <= 1'b1;
          end
`else
          r_elapsed <= tmr_counter;
          r_err     <= 1'b1;
`endif
        end
      end
`ifdef TIMER_SCHED_CANCEL_EN
      else if ((r_state == S_CAPT) && r_capt_phase) begin
        r_elapsed <= tmr_captured;
        r_cancel  <= 1'b1;
      end
`endif
    end
  end

`ifdef TIMER_SCHED_CANCEL_EN
  // CAPT takes two cycles: strobe capture, then read the captured count.
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an)                 r_capt_phase <= 1'b0;
    else if (r_state == S_CAPT)  r_capt_phase <= ~r_capt_phase;
    else                         r_capt_phase <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_timer_sched.sv
// tb_timer_sched: directed bench for timer_sched with a simple timer model.
// Timer model: counter held at 0 while tmr_start is low, counts while high;
// alarm_out is high while enabled and the counter equals the alarm value.
module tb_timer_sched;

  localparam int NUM_REQ = 4;
  localparam int CW      = 32;
  localparam int W       = NUM_REQ + 2 + CW;

  logic                  clk = 1'b0;
  logic                  rst_an = 1'b0;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ*CW-1:0] req_delay = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    cancel = '0;
  logic [NUM_REQ-1:0]    done;
  logic                  done_err;
  logic                  done_cancel;
  logic [CW-1:0]         done_elapsed;
  logic                  busy;
  logic                  tmr_start;
  logic [CW-1:0]         tmr_alarm;
  logic                  tmr_alarm_en;
  logic                  tmr_capture;
  logic [CW-1:0]         tmr_counter = '0;
  logic [CW-1:0]         tmr_captured = '0;
  logic                  tmr_alarm_out;
  logic [2:0]            dbg_state;

  logic                  suppress = 1'b0;
  int                    n_checks = 0;
  int                    n_fail = 0;
  int                    start_cnt = 0;
  int                    capt_cnt = 0;
  logic [W-1:0]          exp_q[$];
  logic [W-1:0]          exp_v;

  timer_sched #(.NUM_REQ(NUM_REQ), .CW(CW)) dut (
    .clk          (clk),
    .rst_an       (rst_an),
    .req_valid    (req_valid),
    .req_delay    (req_delay),
    .req_ready    (req_ready),
    .cancel       (cancel),
    .done         (done),
    .done_err     (done_err),
    .done_cancel  (done_cancel),
    .done_elapsed (done_elapsed),
    .busy         (busy),
    .tmr_start    (tmr_start),
    .tmr_alarm    (tmr_alarm),
    .tmr_alarm_en (tmr_alarm_en),
    .tmr_capture  (tmr_capture),
    .tmr_counter  (tmr_counter),
    .tmr_captured (tmr_captured),
    .tmr_alarm_out(tmr_alarm_out),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / timer model ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!tmr_start) tmr_counter <= '0;
    else            tmr_counter <= tmr_counter + 1'b1;
    if (tmr_capture) tmr_captured <= tmr_counter;
    if (tmr_start)   start_cnt <= start_cnt + 1;
    if (tmr_capture) capt_cnt <= capt_cnt + 1;
  end

  assign tmr_alarm_out = !suppress && tmr_alarm_en && tmr_start && (tmr_counter == tmr_alarm);

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mk_exp(input int idx, input logic err, input logic cncl,
                                          input logic [CW-1:0] el);
    logic [NUM_REQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return {v, err, cncl, el};
  endfunction

  // Scoreboard: every done pulse must match the head of exp_q.
  always @(negedge clk) begin
    if (rst_an && (done != '0)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'(done), 64'd0);
      end else begin
        exp_v = exp_q.pop_front();
        check("done_vec",     64'(done),         64'(exp_v[W-1 -: NUM_REQ]));
        check("done_err",     64'(done_err),     64'(exp_v[CW+1]));
        check("done_cancel",  64'(done_cancel),  64'(exp_v[CW]));
        check("done_elapsed", 64'(done_elapsed), 64'(exp_v[CW-1:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_an = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ctrl", 64'({busy, tmr_start, tmr_alarm_en, tmr_capture, done_err, done_cancel}), 64'd0);
    check("rst_vec",  64'({done, req_ready}), 64'd0);
    check("rst_alarm", 64'(tmr_alarm), 64'd0);
    check("rst_elapsed", 64'(done_elapsed), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    rst_an = 1'b1;
  endtask

  // Call just after a negedge; returns 1 ns after the handshake edge.
  task automatic issue(input int idx, input logic [CW-1:0] dly);
    logic hs_ok;
    logic [NUM_REQ-1:0] exp_rdy;
    exp_rdy = '0;
    exp_rdy[idx] = 1'b1;
    req_delay[idx*CW +: CW] = dly;
    req_valid[idx] = 1'b1;
    #1;
    hs_ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (req_ready != '0) begin
        hs_ok = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    check("hs_seen", 64'(hs_ok), 64'd1);
    check("ready_onehot", 64'(req_ready), 64'(exp_rdy));
    @(posedge clk);
    #1;
    req_valid[idx] = 1'b0;
  endtask

  task automatic wait_counter(input logic [CW-1:0] val);
    logic hit;
    hit = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (tmr_counter == val) begin
        hit = 1'b1;
        break;
      end
    end
    check("counter_reached", 64'(hit), 64'd1);
  endtask

  task automatic drain();
    for (int c = 0; c < 1000; c++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int s0;
    logic [NUM_REQ-1:0] exp_rdy;

    do_reset();

    // First grant after reset, delay 10; non-owner cancel ignored.
    @(negedge clk);
    exp_q.push_back(mk_exp(0, 1'b0, 1'b0, 32'd10));
    issue(0, 32'd10);
    check("arm_state", 64'(dbg_state), 64'd1);
    check("arm_start", 64'(tmr_start), 64'd0);
    check("arm_alarm", 64'(tmr_alarm), 64'd10);
    check("arm_en",    64'(tmr_alarm_en), 64'd1);
    cancel = 4'b0010;
    @(posedge clk);
    #1;
    check("wait_start", 64'(tmr_start), 64'd1);
    drain();
    cancel = '0;

    // Round robin with all requesters held.
    do_reset();
    @(negedge clk);
    for (int i = 0; i < NUM_REQ; i++) req_delay[i*CW +: CW] = 32'd5;
    req_valid = '1;
    #1;
    for (int g = 0; g < 5; g++) begin
      exp_rdy = '0;
      exp_rdy[g % NUM_REQ] = 1'b1;
      for (int c = 0; c < 100; c++) begin
        if (req_ready != '0) break;
        @(negedge clk);
        #1;
      end
      check("rr_grant", 64'(req_ready), 64'(exp_rdy));
      exp_q.push_back(mk_exp(g % NUM_REQ, 1'b0, 1'b0, 32'd5));
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    drain();

    // Zero delay: straight to DONE, timer untouched.
    s0 = start_cnt;
    exp_q.push_back(mk_exp(2, 1'b0, 1'b0, 32'd0));
    issue(2, 32'd0);
    check("zero_done_next", 64'(done), 64'b0100);
    drain();
    check("zero_no_start", 64'(start_cnt - s0), 64'd0);

    // Watchdog with alarm suppressed: fires at counter 23.
    suppress = 1'b1;
    exp_q.push_back(mk_exp(1, 1'b1, 1'b0, 32'd23));
    issue(1, 32'd20);
    drain();
    suppress = 1'b0;

    // Owner cancel at counter 40.
    s0 = capt_cnt;
`ifdef TIMER_SCHED_CANCEL_EN
    exp_q.push_back(mk_exp(3, 1'b0, 1'b1, 32'd41));
`else
    exp_q.push_back(mk_exp(3, 1'b0, 1'b0, 32'd100));
`endif
    issue(3, 32'd100);
    wait_counter(32'd40);
    cancel = 4'b1000;
    @(negedge clk);
    cancel = '0;
    drain();
`ifdef TIMER_SCHED_CANCEL_EN
    check("capture_pulses", 64'(capt_cnt - s0), 64'd1);
`else
    check("capture_pulses", 64'(capt_cnt - s0), 64'd0);
`endif

    // Reset in the middle of WAIT: no done, outputs drop at once.
    issue(1, 32'd50);
    wait_counter(32'd7);
    rst_an = 1'b0;
    #1;
    check("midrst_ctrl", 64'({busy, tmr_start, tmr_alarm_en, tmr_capture, done_err, done_cancel}), 64'd0);
    check("midrst_vec",  64'({done, req_ready}), 64'd0);
    check("midrst_alarm", 64'(tmr_alarm), 64'd0);
    check("midrst_elapsed", 64'(done_elapsed), 64'd0);
    repeat (2) @(negedge clk);
    rst_an = 1'b1;
    @(negedge clk);
    req_delay[3*CW +: CW] = 32'd3;
    req_valid[3] = 1'b1;
    exp_q.push_back(mk_exp(0, 1'b0, 1'b0, 32'd3));
    issue(0, 32'd3);
    req_valid[3] = 1'b0;
    drain();
    check("final_idle", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
